// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared register map, bit positions and helpers for the audio sample feeder
package audio_pkg;

    localparam logic [15:0] REG_DATA  = 16'h0000;
    localparam logic [15:0] REG_RATE  = 16'h0004;
    localparam logic [15:0] REG_CTRL  = 16'h0008;
    localparam logic [15:0] REG_LEVEL = 16'h000C;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_UNDERRUN  = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_LEVEL_LSB = 16;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_FLUSH  = 1;

    localparam logic [7:0] SILENCE = 8'h80;

    function automatic logic [31:0] status_word(
        input logic       empty,
        input logic       full,
        input logic       underrun,
        input logic       ovf,
        input logic [7:0] level
    );
        logic [31:0] s;
        s = '0;
        s[ST_EMPTY]    = empty;
        s[ST_FULL]     = full;
        s[ST_UNDERRUN] = underrun;
        s[ST_OVF]      = ovf;
        s[ST_LEVEL_LSB +: 8] = level;
        return s;
    endfunction

endpackage

// File: rtl/audio_sample_feeder_if.sv
// rtl/audio_sample_feeder_if.sv - control bus bundle (ctrl_wr/rd/addr/wdat -> rdat/done)
interface audio_sample_feeder_if;
    logic [3:0]  ctrl_wr;
    logic        ctrl_rd;
    logic [15:0] ctrl_addr;
    logic [31:0] ctrl_wdat;
    logic [31:0] ctrl_rdat;
    logic        ctrl_done;

    modport master (
        output ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
        input  ctrl_rdat, ctrl_done
    );

    modport slave (
        input  ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
        output ctrl_rdat, ctrl_done
    );
endinterface

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - synchronous sample FIFO with registered read
// Ports: clk, resetn; push/push_data, pop, flush in; rd_data (last popped), full, empty, level out.
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [7:0]    rd_data,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    // A pop frees the slot the push needs, so a full FIFO still accepts a
    // push in a popping cycle. Flush overrides both.
    assign pop_ok  = pop && !empty && !flush;
    assign push_ok = push && !flush && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            rd_data <= SILENCE;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            level <= level + LW'(push_ok) - LW'(pop_ok);
        end
    end

endmodule

// File: rtl/audio_sample_feeder.sv
// rtl/audio_sample_feeder.sv - bus-fed sample FIFO with programmable rate pacer for the PWM stage
// Ports: clk, resetn; ctrl (slave bus: wr/rd/addr/wdat -> rdat/done);
// sample_data/sample_valid to PWM; irq low-water output when AUDIO_FEEDER_IRQ_EN is defined.
module audio_sample_feeder
    import audio_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int DEFAULT_DIV = 2499
) (
    input  logic                  clk,
    input  logic                  resetn,
    audio_sample_feeder_if.slave  ctrl,
    output logic [7:0]            sample_data,
    output logic                  sample_valid
`ifdef AUDIO_FEEDER_IRQ_EN
    ,
    output logic                  irq
`endif
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          done_q;
    logic [31:0]   rdat_q;
    logic          enable_q;
    logic [15:0]   rate_div_q;
    logic [15:0]   cnt_q;
    logic          underrun_q;
    logic          ovf_q;
    logic          valid_q;
    logic          src_fifo_q;

    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;
    logic [7:0]    fifo_rd_data;
    logic [8:0]    level_ext;

    logic          is_wr;
    logic          access;
    logic          wr_access;
    logic          rd_access;
    logic          push;
    logic          flush;
    logic          status_rd;
    logic          tick;
    logic          underrun_evt;
    logic          ovf_evt;
    logic [31:0]   rd_mux;
    logic          unused_bits;

    assign is_wr     = |ctrl.ctrl_wr;
    assign access    = (is_wr || ctrl.ctrl_rd) && !done_q;
    assign wr_access = access && is_wr;
    assign rd_access = access && !is_wr;

    assign push      = wr_access && (ctrl.ctrl_addr == REG_DATA);
    assign flush     = wr_access && (ctrl.ctrl_addr == REG_CTRL) && ctrl.ctrl_wdat[CTRL_FLUSH];
    assign status_rd = rd_access && (ctrl.ctrl_addr == REG_DATA);

    assign tick         = enable_q && (cnt_q == '0);
    // The tick's pop sees the pre-push state, so an empty FIFO underruns even
    // if a push lands in the same cycle. Flush suppresses both sticky events.
    assign underrun_evt = tick && fifo_empty && !flush;
    assign ovf_evt      = push && fifo_full && !tick && !flush;

    assign level_ext   = 9'(fifo_level);
    assign unused_bits = ^{ctrl.ctrl_wdat[31:16], level_ext[8]};

    audio_sample_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (ctrl.ctrl_wdat[7:0]),
        .pop       (tick),
        .flush     (flush),
        .rd_data   (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_comb begin
        rd_mux = '0;
        case (ctrl.ctrl_addr)
            REG_DATA:  rd_mux = status_word(fifo_empty, fifo_full, underrun_q, ovf_q, level_ext[7:0]);
            REG_RATE:  rd_mux = {16'h0000, rate_div_q};
            REG_CTRL:  rd_mux = {31'h0, enable_q};
            REG_LEVEL: rd_mux = {24'h0, level_ext[7:0]};
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            done_q     <= 1'b0;
            rdat_q     <= '0;
            enable_q   <= 1'b0;
            rate_div_q <= 16'(DEFAULT_DIV);
            cnt_q      <= 16'(DEFAULT_DIV);
            underrun_q <= 1'b0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            src_fifo_q <= 1'b0;
        end else begin
            done_q <= access;
            rdat_q <= rd_access ? rd_mux : '0;

            if (wr_access && (ctrl.ctrl_addr == REG_RATE)) begin
                rate_div_q <= ctrl.ctrl_wdat[15:0];
            end
            if (wr_access && (ctrl.ctrl_addr == REG_CTRL)) begin
                enable_q <= ctrl.ctrl_wdat[CTRL_ENABLE];
            end

            // Reload on disable or tick only, so a new RATE_DIV applies at the next reload.
            if (!enable_q || tick) begin
                cnt_q <= rate_div_q;
            end else begin
                cnt_q <= cnt_q - 16'd1;
            end

            // Event in the same cycle as the clearing read wins.
            underrun_q <= (underrun_q && !status_rd) || underrun_evt;
            ovf_q      <= (ovf_q && !status_rd) || ovf_evt;

            valid_q <= tick;
            if (tick) begin
                src_fifo_q <= !fifo_empty && !flush;
            end
        end
    end

    // fifo_rd_data only changes on a real pop, so selecting between it and
    // silence holds the last presented sample between ticks.
    assign sample_data  = src_fifo_q ? fifo_rd_data : SILENCE;
    assign sample_valid = valid_q;

    assign ctrl.ctrl_done = done_q;
    assign ctrl.ctrl_rdat = rdat_q;

`ifdef AUDIO_FEEDER_IRQ_EN
    logic [7:0] thresh_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            thresh_q <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_access && (ctrl.ctrl_addr == REG_LEVEL)) begin
                thresh_q <= ctrl.ctrl_wdat[7:0];
            end
            irq <= enable_q && (level_ext <= {1'b0, thresh_q});
        end
    end
`endif

endmodule

// File: tb/tb_audio_sample_feeder.sv
// tb/tb_audio_sample_feeder.sv - self-checking bench for audio_sample_feeder (irq checks when AUDIO_FEEDER_IRQ_EN)
module tb_audio_sample_feeder;
    localparam int DEPTH = 16;
    localparam logic [15:0] A_DATA  = 16'h0000;
    localparam logic [15:0] A_RATE  = 16'h0004;
    localparam logic [15:0] A_CTRL  = 16'h0008;
    localparam logic [15:0] A_LEVEL = 16'h000C;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] sample_data;
    logic       sample_valid;
`ifdef AUDIO_FEEDER_IRQ_EN
    logic       irq;
`endif

    audio_sample_feeder_if bus();

    audio_sample_feeder #(.DEPTH(DEPTH), .DEFAULT_DIV(2499)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ctrl         (bus),
        .sample_data  (sample_data),
        .sample_valid (sample_valid)
`ifdef AUDIO_FEEDER_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_assert = 0;
    int n_fail = 0;
    int last_done = 0;

    // Reference model: sample queue plus sticky flags.
    logic [7:0] q[$];
    bit m_und = 0;
    bit m_ovf = 0;

    logic [7:0] got_d[$];
    int         got_c[$];

    always @(posedge clk) begin
        #1;
        if (sample_valid === 1'b1) begin
            got_d.push_back(sample_data);
            got_c.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_access(input bit wr, input logic [15:0] a, input logic [31:0] d,
                              output logic [31:0] rd);
        bit ok;
        ok = 0;
        rd = '0;
        bus.ctrl_wr   = wr ? 4'hF : 4'h0;
        bus.ctrl_rd   = !wr;
        bus.ctrl_addr = a;
        bus.ctrl_wdat = d;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.ctrl_done === 1'b1) begin
                rd = bus.ctrl_rdat;
                last_done = cyc;
                ok = 1;
                break;
            end
        end
        bus.ctrl_wr = 4'h0;
        bus.ctrl_rd = 1'b0;
        n_assert++;
        assert (ok) else begin
            n_fail++;
            $error("FAIL bus_timeout: observed no done expected done within 8 cycles at addr 0x%0h", a);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus_access(1, a, d, dummy);
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [31:0] rd);
        bus_access(0, a, 32'h0, rd);
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = '0;
        s[0] = (q.size() == 0);
        s[1] = (q.size() == DEPTH);
        s[2] = m_und;
        s[3] = m_ovf;
        s[23:16] = 8'(q.size());
        return s;
    endfunction

    task automatic check_status(input string tag);
        logic [31:0] r;
        bus_read(A_DATA, r);
        check(tag, r, exp_status());
        m_und = 0;
        m_ovf = 0;
    endtask

    task automatic push_sample(input logic [7:0] d);
        if (q.size() < DEPTH) q.push_back(d);
        else m_ovf = 1;
        bus_write(A_DATA, {24'h0, d});
    endtask

    function automatic logic [7:0] model_tick();
        if (q.size() > 0) return q.pop_front();
        m_und = 1;
        return 8'h80;
    endfunction

    task automatic check_pulses(input int n, input int first, input int period);
        logic [7:0] e;
        check("pulse_count", got_d.size(), n);
        for (int k = 0; k < n; k++) begin
            e = model_tick();
            if (k < got_d.size()) begin
                check("pulse_data", {24'h0, got_d[k]}, {24'h0, e});
                check("pulse_cycle", got_c[k], first + k * period);
            end
        end
        got_d.delete();
        got_c.delete();
    endtask

    initial begin
        logic [31:0] r;
        logic [15:0] rv;
        logic [7:0]  d;
        int          dn;

        bus.ctrl_wr = 4'h0;
        bus.ctrl_rd = 1'b0;
        bus.ctrl_addr = '0;
        bus.ctrl_wdat = '0;

        // Reset state
        step(3);
        resetn = 1'b1;
        check("rst_sample_data", {24'h0, sample_data}, 32'h80);
        check("rst_sample_valid", {31'h0, sample_valid}, 32'h0);
        check("rst_done", {31'h0, bus.ctrl_done}, 32'h0);
        check("rst_rdat", bus.ctrl_rdat, 32'h0);
`ifdef AUDIO_FEEDER_IRQ_EN
        check("rst_irq", {31'h0, irq}, 32'h0);
`endif
        bus_read(A_RATE, r);
        check("rst_rate_div", r, 32'd2499);
        check_status("rst_status");

        // Register access, unmapped address
        rv = 16'($urandom_range(0, 65535));
        bus_write(A_RATE, {16'hFFFF, rv});
        bus_read(A_RATE, r);
        check("rate_readback", r, {16'h0, rv});
        bus_write(16'h0010, 32'hFFFF_FFFF);
        bus_read(16'h0010, r);
        check("unmapped_read", r, 32'h0);

        // Three samples at RATE_DIV=3, then underrun
        bus_write(A_RATE, 32'd3);
        for (int i = 0; i < 3; i++) push_sample(8'($urandom_range(0, 255)));
        check_status("status_three");
        got_d.delete(); got_c.delete();
        bus_write(A_CTRL, 32'h1);
        dn = last_done;
        step(16);
        bus_write(A_CTRL, 32'h0);
        step(2);
        check_pulses(4, dn + 4, 4);
        check_status("status_underrun");
        check_status("status_underrun_cleared");

        // Overflow with ENABLE=0, then drain at RATE_DIV=1
        for (int i = 0; i < 17; i++) push_sample(8'($urandom_range(0, 255)));
        bus_read(A_LEVEL, r);
        check("level_reg_full", r, 32'd16);
        check_status("status_ovf");
        bus_write(A_RATE, 32'd1);
        bus_write(A_CTRL, 32'h1);
        dn = last_done;
        step(31);
        bus_write(A_CTRL, 32'h0);
        step(2);
        check_pulses(16, dn + 2, 2);
        check_status("status_drained");

        // Full FIFO, push coincident with a tick
        for (int i = 0; i < 16; i++) push_sample(8'($urandom_range(0, 255)));
        bus_write(A_RATE, 32'd2);
        bus_write(A_CTRL, 32'h1);
        dn = last_done;
        step(2);
        d = 8'($urandom_range(0, 255));
        bus_write(A_DATA, {24'h0, d});
        bus_write(A_CTRL, 32'h0);
        step(2);
        check_pulses(1, dn + 3, 3);
        q.push_back(d);
        check_status("status_full_pushpop");

        // Flush coincident with a tick
        bus_write(A_CTRL, 32'h2);
        q.delete();
        check_status("status_flushed");
        for (int i = 0; i < 5; i++) push_sample(8'($urandom_range(0, 255)));
        got_d.delete(); got_c.delete();
        bus_write(A_CTRL, 32'h1);
        dn = last_done;
        step(2);
        bus_write(A_CTRL, 32'h3);
        q.delete();
        bus_write(A_CTRL, 32'h0);
        step(2);
        check("flush_pulse_count", got_d.size(), 1);
        if (got_d.size() > 0) begin
            check("flush_pulse_data", {24'h0, got_d[0]}, 32'h80);
            check("flush_pulse_cycle", got_c[0], dn + 3);
        end
        got_d.delete(); got_c.delete();
        check_status("status_flush_tick");

`ifdef AUDIO_FEEDER_IRQ_EN
        // Low-water interrupt
        bus_write(A_LEVEL, 32'd2);
        bus_read(A_LEVEL, r);
        check("level_reg_empty", r, 32'd0);
        for (int i = 0; i < 4; i++) push_sample(8'($urandom_range(0, 255)));
        bus_write(A_RATE, 32'd3);
        check("irq_disabled", {31'h0, irq}, 32'h0);
        bus_write(A_CTRL, 32'h1);
        dn = last_done;
        step(8);
        check("irq_level2_same_cycle", {31'h0, irq}, 32'h0);
        step(1);
        check("irq_rise", {31'h0, irq}, 32'h1);
        push_sample(8'($urandom_range(0, 255)));
        check("irq_hold", {31'h0, irq}, 32'h1);
        step(1);
        check("irq_fall", {31'h0, irq}, 32'h0);
        bus_write(A_CTRL, 32'h0);
        step(3);
        check_pulses(3, dn + 4, 4);
        check("irq_off", {31'h0, irq}, 32'h0);
        bus_write(A_CTRL, 32'h2);
        q.delete();
        check_status("status_irq_flushed");
`else
        // Without the irq feature, LEVEL writes are ignored but reads return level
        push_sample(8'($urandom_range(0, 255)));
        bus_write(A_LEVEL, 32'hFF);
        bus_read(A_LEVEL, r);
        check("level_reg_one", r, 32'd1);
        bus_write(A_CTRL, 32'h2);
        q.delete();
        check_status("status_flushed_again");
`endif

        // Reset mid-operation discards contents and the pending access
        for (int i = 0; i < 3; i++) push_sample(8'($urandom_range(0, 255)));
        bus.ctrl_rd = 1'b1;
        bus.ctrl_addr = A_DATA;
        resetn = 1'b0;
        step(1);
        check("reset_no_done", {31'h0, bus.ctrl_done}, 32'h0);
        step(1);
        bus.ctrl_rd = 1'b0;
        resetn = 1'b1;
        check("reset_no_done2", {31'h0, bus.ctrl_done}, 32'h0);
        q.delete();
        m_und = 0;
        m_ovf = 0;
        check_status("status_after_reset");
        check("sample_after_reset", {24'h0, sample_data}, 32'h80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
